poly_sub_engine: RTL and testbench

POLY_SUB_ENGINE -- requirements
Module: poly_sub_engine

---
 rtl/poly_pkg.sv | 23 ++
 rtl/poly_sub_engine_mod_q_mul.sv | 20 ++
 rtl/poly_sub_engine.sv | 136 +++++++++++++
 tb/tb_poly_sub_engine.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial add/subtract engine.
//   COEF_W_DEF / ADDR_W_DEF / Q_DEF : default coefficient width, address width, modulus
//   mode_e  : operation select (add, sub, scaled sub, copy A)
//   state_e : sequencer states
package poly_pkg;
  localparam int COEF_W_DEF = 13;
  localparam int ADDR_W_DEF = 11;
  localparam int Q_DEF      = 4591;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_SSUB = 2'b10,
    MODE_COPY = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/poly_sub_engine_mod_q_mul.sv
// Combinational modular multiply p = (a * b) mod Q.
//   a, b : operands in [0, Q-1]
//   p    : reduced product in [0, Q-1]
module mod_q_mul #(
  parameter int COEF_W = 13,
  parameter int Q      = 4591
) (
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [COEF_W-1:0] p
);
  localparam int PW = 2 * COEF_W;

  logic [PW-1:0] prod;

  always_comb begin
    prod = PW'(a) * PW'(b);
    p    = COEF_W'(prod % PW'(Q));
  end
endmodule

// File: rtl/poly_sub_engine.sv
// Polynomial coefficient engine: S[i] = A[i] op B[i-k], k = deg_n - deg_d,
// walking i from deg_n down to 0, one index per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   start/mode/scale    : launch pulse and operation (latched on accept)
//   deg_n, deg_d        : degrees of A and B
//   addr_a/rd_data_a    : memory A read port (1-cycle read latency)
//   addr_b/rd_data_b    : memory B read port (1-cycle read latency)
//   wr_addr/wr_data/wr_en : memory S write port
//   busy, done, err     : status
//   deg_out, zero_flag  : result degree / all-zero indication
module poly_sub_engine
  import poly_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int Q      = Q_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [COEF_W-1:0] scale,
  input  logic [ADDR_W-1:0] deg_n,
  input  logic [ADDR_W-1:0] deg_d,
  output logic [ADDR_W-1:0] addr_a,
  input  logic [COEF_W-1:0] rd_data_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [COEF_W-1:0] rd_data_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [COEF_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] deg_out,
  output logic              zero_flag
);
  localparam int STAGES = 2;

  state_e            state, state_nx;
  mode_e             mode_r;
  logic [COEF_W-1:0] scale_r;
  logic [ADDR_W-1:0] idx, idx1, k_r;
  logic [STAGES:1]   vld_pipe;  // [1]: read data valid, [2]: write strobe
  logic              b_live1;

  logic              accept, deg_bad, b_live;
  logic [COEF_W-1:0] b_term, cb_mod, rhs, res;
  logic [COEF_W:0]   sum_x, diff_x;

  assign accept  = (state == S_IDLE) && start;
  assign deg_bad = deg_d > deg_n;
  assign b_live  = idx >= k_r;  // below the shift the B term is zero
  assign busy    = (state == S_RUN) || (state == S_DRAIN);
  assign done    = (state == S_DONE);
  assign wr_en   = vld_pipe[2];
  assign addr_a  = idx;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = deg_bad ? S_DONE : S_RUN;
      S_RUN:   if (idx == '0) state_nx = S_DRAIN;
      S_DRAIN: if (!vld_pipe[1]) state_nx = S_DONE;  // last write is on the bus
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  mod_q_mul #(.COEF_W(COEF_W), .Q(Q)) u_mul (.a(scale_r), .b(b_term), .p(cb_mod));

  always_comb begin
    b_term = b_live1 ? rd_data_b : '0;
    rhs    = (mode_r == MODE_SSUB) ? cb_mod : b_term;
    sum_x  = {1'b0, rd_data_a} + {1'b0, b_term};
    if (sum_x >= (COEF_W+1)'(Q)) sum_x = sum_x - (COEF_W+1)'(Q);
    if (rd_data_a >= rhs) diff_x = {1'b0, rd_data_a} - {1'b0, rhs};
    else                  diff_x = {1'b0, rd_data_a} + (COEF_W+1)'(Q) - {1'b0, rhs};
    case (mode_r)
      MODE_ADD:  res = COEF_W'(sum_x);
      MODE_COPY: res = rd_data_a;
      default:   res = COEF_W'(diff_x);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      idx1      <= '0;
      k_r       <= '0;
      addr_b    <= '0;
      mode_r    <= MODE_ADD;
      scale_r   <= '0;
      vld_pipe  <= '0;
      b_live1   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err       <= 1'b0;
      deg_out   <= '1;
      zero_flag <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], state == S_RUN};
      b_live1  <= b_live;
      idx1     <= idx;
      if (accept) begin
        mode_r    <= mode_e'(mode);
        scale_r   <= scale;
        err       <= deg_bad;
        deg_out   <= '1;
        zero_flag <= 1'b1;
        if (!deg_bad) begin
          idx    <= deg_n;
          addr_b <= deg_d;
          k_r    <= deg_n - deg_d;
        end
      end else if (state == S_RUN && idx != '0) begin
        idx <= idx - 1'b1;
        if ((idx - 1'b1) >= k_r) addr_b <= idx - 1'b1 - k_r;
      end
      if (vld_pipe[1]) begin
        wr_addr <= idx1;
        wr_data <= res;
        // first nonzero coefficient seen is the highest one
        if (zero_flag && res != '0) begin
          zero_flag <= 1'b0;
          deg_out   <= idx1;
        end
      end
    end
  end
endmodule

// File: tb/tb_poly_sub_engine.sv
module tb_poly_sub_engine;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  mode;
  logic [12:0] scale;
  logic [10:0] deg_n, deg_d;
  logic [10:0] addr_a, addr_b, wr_addr, deg_out;
  logic [12:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en, busy, done, err, zero_flag;

  logic [12:0] mem_a [16];
  logic [12:0] mem_b [16];
  logic [12:0] s_mem [16];

  int passed = 0, total = 0;
  int lat, nwr;
  bit order_ok, got_done, quiet;

  always #5 clk = ~clk;

  poly_sub_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .scale(scale),
    .deg_n(deg_n), .deg_d(deg_d), .addr_a(addr_a), .rd_data_a(rd_data_a),
    .addr_b(addr_b), .rd_data_b(rd_data_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .busy(busy), .done(done), .err(err), .deg_out(deg_out),
    .zero_flag(zero_flag)
  );

  always @(posedge clk) begin
    rd_data_a <= mem_a[addr_a[3:0]];
    rd_data_b <= mem_b[addr_b[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic load(input logic [12:0] a0, a1, a2, a3, b0, b1, b2, b3);
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; s_mem[i] = 13'h1fff;
    end
    mem_a[0] = a0; mem_a[1] = a1; mem_a[2] = a2; mem_a[3] = a3;
    mem_b[0] = b0; mem_b[1] = b1; mem_b[2] = b2; mem_b[3] = b3;
  endtask

  // Launch one operation, record writes at each falling edge until done.
  task automatic run_op(input logic [1:0] m, input logic [12:0] c, input int dn, input int dd);
    int nxt;
    @(negedge clk);
    mode = m; scale = c; deg_n = 11'(dn); deg_d = 11'(dd); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; nwr = 0; order_ok = 1'b1; got_done = 1'b0; nxt = dn;
    for (int n = 1; n <= 64; n++) begin
      if (wr_en) begin
        nwr++;
        if (int'(wr_addr) != nxt) order_ok = 1'b0;
        nxt--;
        s_mem[wr_addr[3:0]] = wr_data;
      end
      if (done) begin
        lat = n; got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; scale = '0; deg_n = '0; deg_d = '0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_ctl", {wr_en, busy, done, err, zero_flag}, 5'b0);
    chk("rst_addr", {addr_a, addr_b, wr_addr}, 33'h0);
    chk("rst_wdata", 32'(wr_data), 0);
    chk("rst_deg_out", 32'(deg_out), 2047);
    rst = 1'b0;

    // A=[5,3,1] - B=[1,1,1]
    load(5, 3, 1, 0, 1, 1, 1, 0);
    run_op(2'b01, 0, 2, 2);
    chk("sub3_done", 32'(got_done), 1);
    chk("sub3_lat", lat, 6);
    chk("sub3_s", {s_mem[2], s_mem[1], s_mem[0]}, {13'd0, 13'd2, 13'd4});
    chk("sub3_nwr", nwr, 3);
    chk("sub3_order", 32'(order_ok), 1);
    chk("sub3_deg", 32'(deg_out), 1);
    chk("sub3_zero_err", {zero_flag, err}, 2'b00);
    @(negedge clk);
    chk("sub3_done_pulse", 32'(done), 0);

    load(0, 0, 0, 0, 1, 0, 0, 0);
    run_op(2'b01, 0, 0, 0);
    chk("sub_wrap", 32'(s_mem[0]), 4590);
    chk("deg0_lat", lat, 4);
    chk("deg0_nwr", nwr, 1);

    load(4590, 0, 0, 0, 2, 0, 0, 0);
    run_op(2'b00, 0, 0, 0);
    chk("add_wrap", 32'(s_mem[0]), 1);
    chk("add_deg", {deg_out, zero_flag}, {11'd0, 1'b0});

    load(0, 0, 0, 0, 4590, 0, 0, 0);
    run_op(2'b10, 2, 0, 0);
    chk("ssub_c2", 32'(s_mem[0]), 2);

    load(7, 0, 0, 0, 1, 0, 0, 0);
    run_op(2'b10, 4590, 0, 0);
    chk("ssub_cbig", 32'(s_mem[0]), 8);

    // shifted subtract: k = 2
    load(9, 9, 9, 9, 2, 3, 0, 0);
    run_op(2'b01, 0, 3, 1);
    chk("shift_s", {s_mem[3], s_mem[2], s_mem[1], s_mem[0]},
        {13'd6, 13'd7, 13'd9, 13'd9});
    chk("shift_lat", lat, 7);
    chk("shift_order", {32'(order_ok), nwr}, {32'd1, 32'd4});
    chk("shift_deg", 32'(deg_out), 3);

    // copy A ignores B entirely
    load(0, 0, 5, 0, 7, 7, 7, 7);
    run_op(2'b11, 0, 3, 3);
    chk("copy_s", {s_mem[3], s_mem[2], s_mem[1], s_mem[0]},
        {13'd0, 13'd5, 13'd0, 13'd0});
    chk("copy_deg", 32'(deg_out), 2);

    load(1, 2, 3, 0, 1, 2, 3, 0);
    run_op(2'b01, 0, 2, 2);
    chk("zero_s", {s_mem[2], s_mem[1], s_mem[0]}, 39'h0);
    chk("zero_flags", {deg_out, zero_flag}, {11'd2047, 1'b1});

    load(1, 2, 3, 0, 1, 2, 3, 0);
    run_op(2'b01, 0, 1, 2);
    chk("err_flags", {err, zero_flag, deg_out}, {1'b1, 1'b1, 11'd2047});
    chk("err_lat", lat, 1);
    chk("err_nwr", nwr, 0);

    // next accepted start clears err
    load(3, 0, 0, 0, 1, 0, 0, 0);
    run_op(2'b01, 0, 0, 0);
    chk("err_clear", {err, 13'(s_mem[0])}, {1'b0, 13'd2});

    // reset two cycles into a long operation
    load(1, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    mode = 2'b00; deg_n = 11'd10; deg_d = 11'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctl", {wr_en, busy, done}, 3'b000);
    quiet = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (wr_en || done || busy) quiet = 1'b0;
      @(negedge clk);
    end
    chk("midrst_quiet", 32'(quiet), 1);

    load(4, 6, 0, 0, 1, 1, 0, 0);
    run_op(2'b00, 0, 1, 1);
    chk("post_rst_s", {s_mem[1], s_mem[0]}, {13'd7, 13'd5});
    chk("post_rst_lat", lat, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
